// File: rtl/cachepkg.sv
// Shared cache-hierarchy types: request opcodes, flag enums, and the
// line_memory FSM state encodings.
package cachepkg;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RFO   = 2'd3
    } op_t;

    typedef enum logic {
        INVALID = 1'b0,
        VALID   = 1'b1
    } valid_t;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND,
        WAIT_DROP
    } mem_state_t;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } snoop_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/line_memory_if.sv
// Cache-to-backing-store link: next-level request/response plus the
// snoop injection and evict path toward the cache.
interface line_memory_if
    import cachepkg::*;
#(
    parameter int ADDRWIDTH = 32,
    parameter int LINEWIDTH = 512
);
    logic                 request;
    op_t                  operation;
    logic [ADDRWIDTH-1:0] addr_in;
    logic [LINEWIDTH-1:0] d_in;
    logic [LINEWIDTH-1:0] d_out;
    logic                 valid;
    logic                 evict;
    logic [ADDRWIDTH-1:0] addr_out;
    logic                 snoop_req;
    logic [ADDRWIDTH-1:0] snoop_addr;
    logic                 snoop_ready;

    modport master (
        output request, operation, addr_in, d_in, snoop_req, snoop_addr,
        input  d_out, valid, evict, addr_out, snoop_ready
    );

    modport slave (
        input  request, operation, addr_in, d_in, snoop_req, snoop_addr,
        output d_out, valid, evict, addr_out, snoop_ready
    );
endinterface

// File: rtl/line_memory_line_store.sv
// Line storage array: synchronous write, combinational read, contents
// deliberately not reset so they survive a reset pulse.
module line_store #(
    parameter int LINEWIDTH = 512,
    parameter int DEPTH     = 1024,
    parameter int IDXW      = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [IDXW-1:0]      waddr,
    input  logic [LINEWIDTH-1:0] wdata,
    input  logic [IDXW-1:0]      raddr,
    output logic [LINEWIDTH-1:0] rdata
);
    logic [LINEWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/line_memory.sv
// Backing store below the cache: fixed-latency whole-line READ/RFO/WRITE
// service, a snoop injector driving evict, and saturating op counters.
module line_memory
    import cachepkg::*;
#(
    parameter int ADDRWIDTH    = 32,
    parameter int LINEWIDTH    = 512,
    parameter int LINE_OFFSET  = 6,
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 4,
    parameter int SNOOP_CYCLES = 8
) (
    input  logic             clock,
    input  logic             reset,
    line_memory_if.slave     bus,
    output logic [15:0]      rd_count,
    output logic [15:0]      wr_count,
    output logic [15:0]      rfo_count
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int LCW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SCW  = $clog2(SNOOP_CYCLES + 1);

    mem_state_t           state;
    snoop_state_t         s_state;
    op_t                  op_q;
    op_t                  resp_op;
    logic [IDXW-1:0]      idx_q;
    logic [IDXW-1:0]      req_idx;
    logic [IDXW-1:0]      resp_idx;
    logic [IDXW-1:0]      snoop_idx;
    logic [LINEWIDTH-1:0] data_q;
    logic [LINEWIDTH-1:0] rd_line;
    logic [LCW-1:0]       lat_cnt;
    logic [SCW-1:0]       hold_cnt;
    logic                 accept;
    logic                 enter_resp;
    logic                 store_we;
    logic                 snoop_accept;
    logic                 write_hit;

    assign req_idx    = bus.addr_in[LINE_OFFSET +: IDXW];
    assign accept     = (state == IDLE) && bus.request && (bus.operation != NOP);
    // LATENCY==1 responds straight from IDLE, so the response op/index
    // come from the live request rather than the latched copy.
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state == BUSY) && (lat_cnt == LCW'(1)));
    assign resp_op    = (state == IDLE) ? bus.operation : op_q;
    assign resp_idx   = (state == IDLE) ? req_idx : idx_q;
    assign store_we   = (state == RESPOND) && (op_q == WRITE);
    assign write_hit  = store_we && (idx_q == snoop_idx);

    assign bus.snoop_ready = reset && (s_state == S_IDLE) && (state == IDLE) && !bus.request;
    assign snoop_accept    = bus.snoop_req && bus.snoop_ready;

    line_store #(
        .LINEWIDTH (LINEWIDTH),
        .DEPTH     (DEPTH),
        .IDXW      (IDXW)
    ) u_store (
        .clock (clock),
        .we    (store_we),
        .waddr (idx_q),
        .wdata (data_q),
        .raddr (resp_idx),
        .rdata (rd_line)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= NOP;
            idx_q     <= '0;
            data_q    <= '0;
            lat_cnt   <= '0;
            bus.valid <= 1'b0;
            bus.d_out <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            rfo_count <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= bus.operation;
                        idx_q   <= req_idx;
                        data_q  <= bus.d_in;
                        lat_cnt <= LCW'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? RESPOND : BUSY;
                    end
                end
                BUSY: begin
                    lat_cnt <= lat_cnt - LCW'(1);
                    if (lat_cnt == LCW'(1)) state <= RESPOND;
                end
                RESPOND: state <= WAIT_DROP;
                WAIT_DROP: begin
                    if (!bus.request) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                bus.valid <= 1'b1;
                case (resp_op)
                    READ: begin
                        bus.d_out <= rd_line;
                        rd_count  <= sat_inc(rd_count);
                    end
                    RFO: begin
                        bus.d_out <= rd_line;
                        rfo_count <= sat_inc(rfo_count);
                    end
                    WRITE:   wr_count <= sat_inc(wr_count);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_state      <= S_IDLE;
            bus.evict    <= 1'b0;
            bus.addr_out <= '0;
            snoop_idx    <= '0;
            hold_cnt     <= '0;
        end else begin
            case (s_state)
                S_IDLE: begin
                    if (snoop_accept) begin
                        s_state      <= S_HOLD;
                        bus.evict    <= 1'b1;
                        bus.addr_out <= {bus.snoop_addr[ADDRWIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
                        snoop_idx    <= bus.snoop_addr[LINE_OFFSET +: IDXW];
                        hold_cnt     <= SCW'(SNOOP_CYCLES);
                    end
                end
                S_HOLD: begin
                    // The cache's writeback of the snooped line ends the hold early.
                    if ((hold_cnt == SCW'(1)) || write_hit) begin
                        s_state   <= S_IDLE;
                        bus.evict <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - SCW'(1);
                    end
                end
                default: s_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory: driver pushes expected responses from a
// line-array reference model, a negedge monitor pops and compares on valid.
module tb_line_memory;
    import cachepkg::*;

    localparam int AW  = 32;
    localparam int LW  = 512;
    localparam int DEP = 1024;
    localparam int LAT = 4;
    localparam int SNC = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] rd_count, wr_count, rfo_count;

    line_memory_if #(.ADDRWIDTH(AW), .LINEWIDTH(LW)) bus ();

    line_memory #(
        .ADDRWIDTH    (AW),
        .LINEWIDTH    (LW),
        .LINE_OFFSET  (6),
        .DEPTH        (DEP),
        .LATENCY      (LAT),
        .SNOOP_CYCLES (SNC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .rfo_count (rfo_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        op_t           op;
        logic [LW-1:0] data;
        int            issue;
        int            rd;
        int            wr;
        int            rfo;
    } exp_t;

    exp_t          sb[$];
    exp_t          me;
    logic [LW-1:0] model [int];
    logic [LW-1:0] m_dout = '0;
    int            m_rd = 0, m_wr = 0, m_rfo = 0;
    int            compared = 0, mismatched = 0;
    int            cyc = 0, valid_seen = 0, last_drop = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int line_of(input logic [AW-1:0] a);
        return int'((a >> 6) % DEP);
    endfunction

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset && bus.valid) begin
            valid_seen++;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected no response", cyc);
            end else begin
                me = sb.pop_front();
                check("latency", LW'(cyc - me.issue), LW'(LAT));
                check("d_out", bus.d_out, me.data);
                check("rd_count", LW'(rd_count), LW'(me.rd));
                check("wr_count", LW'(wr_count), LW'(me.wr));
                check("rfo_count", LW'(rfo_count), LW'(me.rfo));
            end
        end
    end

    task automatic do_req(input op_t op, input logic [AW-1:0] a, input logic [LW-1:0] d, input int hold);
        exp_t e;
        int   idx;
        int   start;
        bit   got;
        idx  = line_of(a);
        e.op = op;
        case (op)
            READ, RFO: begin
                e.data = model[idx];
                m_dout = model[idx];
                if (op == READ) m_rd = sat(m_rd); else m_rfo = sat(m_rfo);
            end
            default: begin
                e.data     = m_dout;
                model[idx] = d;
                m_wr       = sat(m_wr);
            end
        endcase
        e.rd = m_rd; e.wr = m_wr; e.rfo = m_rfo;
        bus.request   = 1'b1;
        bus.operation = op;
        bus.addr_in   = a;
        bus.d_in      = d;
        e.issue       = cyc;
        sb.push_back(e);
        start = valid_seen;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (valid_seen != start) got = 1'b1;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL valid_timeout: got no valid for op %0d addr %0h expected one within %0d cycles", op, a, LAT);
            e = sb.pop_back();
        end
        repeat (hold) step();
        bus.request = 1'b0;
        bus.d_in    = {16{$urandom}};
        last_drop   = cyc;
        step();
        step();
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int unsigned i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n;
        int            first;
        int            vs;
        logic [LW-1:0] old_line;
        logic [AW-1:0] a;
        op_t           op;

        bus.request    = 1'b0;
        bus.operation  = NOP;
        bus.addr_in    = '0;
        bus.d_in       = '0;
        bus.snoop_req  = 1'b0;
        bus.snoop_addr = '0;
        step();
        step();
        check("rst_valid", LW'(bus.valid), '0);
        check("rst_evict", LW'(bus.evict), '0);
        check("rst_d_out", bus.d_out, '0);
        check("rst_addr_out", LW'(bus.addr_out), '0);
        check("rst_snoop_ready", LW'(bus.snoop_ready), '0);
        check("rst_counts", LW'({rd_count, wr_count, rfo_count}), '0);
        reset = 1'b1;
        step();

        do_req(WRITE, 32'h0000_0040, {64{8'hA5}}, 0);
        do_req(READ,  32'h0000_0040, '0, 0);
        do_req(WRITE, 32'h0000_0080, {16{32'h1234_5678}}, 3);
        do_req(RFO,   32'h0000_0080, '0, 3);
        do_req(WRITE, 32'h0001_0040, {16{32'hCAFE_F00D}}, 1);
        do_req(READ,  32'h0000_0040, '0, 2);

        // NOP requests are ignored
        vs = valid_seen;
        bus.request   = 1'b1;
        bus.operation = NOP;
        repeat (LAT + 3) step();
        bus.request = 1'b0;
        step();
        check("nop_no_valid", LW'(valid_seen), LW'(vs));

        // Snoop with no writeback: evict held SNOOP_CYCLES cycles
        bus.snoop_req  = 1'b1;
        bus.snoop_addr = 32'h0000_00C7;
        check("snoop_ready_idle", LW'(bus.snoop_ready), LW'(1));
        step();
        bus.snoop_req = 1'b0;
        check("evict_rise", LW'(bus.evict), LW'(1));
        check("addr_out", LW'(bus.addr_out), LW'(32'h0000_00C0));
        n = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (!bus.evict) break;
            n++;
        end
        check("evict_len_timeout", LW'(n), LW'(SNC));
        step();

        // Snoop ended early by a WRITE to the same line
        bus.snoop_req  = 1'b1;
        bus.snoop_addr = 32'h0000_00C7;
        step();
        bus.snoop_req = 1'b0;
        check("evict_rise2", LW'(bus.evict), LW'(1));
        n = 1;
        fork
            do_req(WRITE, 32'h0000_00C0, rand_line(), 0);
            begin
                for (int i = 0; i < 30; i++) begin
                    step();
                    if (!bus.evict) break;
                    n++;
                end
            end
        join
        check("evict_len_writeback", LW'(n), LW'(LAT + 1));

        // Request and snoop together: request wins, snoop follows the drop
        first = -1;
        bus.snoop_addr = 32'h0000_0140;
        bus.snoop_req  = 1'b1;
        fork
            do_req(READ, 32'h0000_0080, '0, 3);
            begin
                #1;
                check("snoop_ready_conflict", LW'(bus.snoop_ready), '0);
                for (int i = 0; i < 40; i++) begin
                    step();
                    if (bus.evict) begin
                        first = cyc;
                        bus.snoop_req = 1'b0;
                        break;
                    end
                end
            end
        join
        bus.snoop_req = 1'b0;
        check("snoop_after_drop", LW'(first), LW'(last_drop + 2));
        check("addr_out2", LW'(bus.addr_out), LW'(32'h0000_0140));
        for (int i = 0; i < 30 && bus.evict; i++) step();
        step();

        // Reset during BUSY of a WRITE: nothing commits, counters clear
        old_line = rand_line();
        do_req(WRITE, 32'h0000_0100, old_line, 0);
        vs = valid_seen;
        bus.request   = 1'b1;
        bus.operation = WRITE;
        bus.addr_in   = 32'h0000_0100;
        bus.d_in      = ~old_line;
        step();
        step();
        reset       = 1'b0;
        bus.request = 1'b0;
        step();
        check("midrst_counts", LW'({rd_count, wr_count, rfo_count}), '0);
        check("midrst_d_out", bus.d_out, '0);
        reset = 1'b1;
        m_rd = 0; m_wr = 0; m_rfo = 0; m_dout = '0;
        repeat (LAT + 4) step();
        check("midrst_no_valid", LW'(valid_seen), LW'(vs));
        do_req(READ, 32'h0000_0100, '0, 1);

        // Randomized traffic over a few lines with aliasing upper bits
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 7);
            a = ($urandom & 32'hFFFF_0000) | (32'(n) << 6) | 32'($urandom_range(0, 63));
            if (!model.exists(line_of(a))) op = WRITE;
            else begin
                case ($urandom_range(0, 2))
                    0:       op = READ;
                    1:       op = RFO;
                    default: op = WRITE;
                endcase
            end
            do_req(op, a, rand_line(), $urandom_range(0, 3));
        end

        repeat (3) step();
        check("sb_drained", LW'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
